// File: rtl/scanchain_host.sv
// Host-side driver for the 70-bit SERV scan chain: captures the Wishbone request, serves it, and shifts back {rdt, ack, timer_irq}.
// Optional internal mtime/mtimecmp timer enabled by defining SCANCHAIN_HOST_TIMER_EN.
module scanchain_host #(
   parameter int unsigned SCAN_LENGTH = 70,
   parameter int unsigned IN_BITS     = 34,
   parameter int unsigned CLK_DIV     = 2
`ifdef SCANCHAIN_HOST_TIMER_EN
   ,
   parameter logic [31:0] TIMER_BASE  = 32'h8000_0000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   output logic        sc_clk_out,
   output logic        sc_data_out,
   output logic        sc_select_out,
   input  logic        sc_data_in,
   output logic        serv_clk_out,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        ext_irq,
   output logic        busy
);

   localparam int unsigned PERIOD = 2 * CLK_DIV;
   localparam int unsigned CNT_W  = $clog2(PERIOD);
   localparam int unsigned BIT_W  = $clog2(SCAN_LENGTH);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      SHIFT,
      APPLY,
      SERVCLK,
      DECODE,
      MEMWAIT
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [BIT_W-1:0]       bit_idx;
   logic [SCAN_LENGTH-1:0] tx;
   logic [SCAN_LENGTH-1:0] rx;
   logic                   resp_ack;
   logic [31:0]            resp_rdt;
   logic                   acc_pend;
   logic                   acc_int;

   logic [CNT_W-1:0]       cnt_inc;
   logic                   low_end;
   logic                   period_end;
   logic                   irq_now;
   logic                   req_timer;
   logic [SCAN_LENGTH-1:0] tx_init;

   logic                   req_cyc;
   logic                   req_we;
   logic [3:0]             req_sel;
   logic [31:0]            req_dat;
   logic [31:0]            req_adr;

   assign cnt_inc    = cnt + CNT_W'(1);
   assign low_end    = (cnt == CNT_W'(CLK_DIV - 1));
   assign period_end = (cnt == CNT_W'(PERIOD - 1));

   // Captured request, in the order the bits leave the chain.
   assign req_cyc = rx[0];
   assign req_we  = rx[1];
   assign req_sel = rx[5:2];
   assign req_dat = rx[37:6];
   assign req_adr = rx[69:38];

   // Response word is sent MSB first so timer_irq is the last bit shifted in.
   assign tx_init = {{(SCAN_LENGTH - IN_BITS){1'b0}}, resp_rdt, resp_ack, irq_now};

`ifdef SCANCHAIN_HOST_TIMER_EN
   logic [31:0] mtime;
   logic [31:0] mtimecmp;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   assign irq_now   = (mtime >= mtimecmp);
   assign req_timer = (req_adr[31:3] == TIMER_BASE[31:3]);
`else
   assign irq_now   = ext_irq;
   assign req_timer = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         tx            <= '0;
         rx            <= '0;
         resp_ack      <= 1'b0;
         resp_rdt      <= '0;
         acc_pend      <= 1'b0;
         acc_int       <= 1'b0;
         sc_clk_out    <= 1'b0;
         sc_data_out   <= 1'b0;
         sc_select_out <= 1'b0;
         serv_clk_out  <= 1'b0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wstrb     <= '0;
         busy          <= 1'b0;
`ifdef SCANCHAIN_HOST_TIMER_EN
         mtime         <= '0;
         mtimecmp      <= 32'hFFFF_FFFF;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state         <= CAPTURE;
                  cnt           <= '0;
                  busy          <= 1'b1;
                  sc_select_out <= 1'b1;
                  sc_clk_out    <= 1'b0;
               end
            end

            // One select pulse; the rising scan-clock edge loads or applies the chain.
            CAPTURE, APPLY: begin
               cnt <= cnt_inc;
               if (low_end) sc_clk_out <= 1'b1;
               if (period_end) begin
                  cnt           <= '0;
                  sc_clk_out    <= 1'b0;
                  sc_select_out <= 1'b0;
                  if (state == CAPTURE) begin
                     state       <= SHIFT;
                     bit_idx     <= '0;
                     tx          <= tx_init << 1;
                     sc_data_out <= tx_init[SCAN_LENGTH-1];
                  end else begin
                     state        <= SERVCLK;
                     serv_clk_out <= 1'b1;
`ifdef SCANCHAIN_HOST_TIMER_EN
                     mtime        <= mtime + 32'd1;
`endif
                  end
               end
            end

            SHIFT: begin
               cnt <= cnt_inc;
               if (low_end) begin
                  sc_clk_out <= 1'b1;
                  rx         <= {sc_data_in, rx[SCAN_LENGTH-1:1]};
               end
               if (period_end) begin
                  cnt        <= '0;
                  sc_clk_out <= 1'b0;
                  if (bit_idx == BIT_W'(SCAN_LENGTH - 1)) begin
                     state         <= APPLY;
                     sc_select_out <= 1'b1;
                     sc_data_out   <= 1'b0;
                  end else begin
                     bit_idx     <= bit_idx + BIT_W'(1);
                     sc_data_out <= tx[SCAN_LENGTH-1];
                     tx          <= {tx[SCAN_LENGTH-2:0], 1'b0};
                  end
               end
            end

            // Decode happens on the edge leaving SERVCLK so mem_en is high during DECODE.
            SERVCLK: begin
               cnt <= cnt_inc;
               if (low_end) serv_clk_out <= 1'b0;
               if (period_end) begin
                  cnt      <= '0;
                  state    <= DECODE;
                  acc_pend <= 1'b0;
                  if (resp_ack) begin
                     resp_ack <= 1'b0;
                  end else if (req_cyc) begin
                     acc_pend  <= 1'b1;
                     acc_int   <= req_timer;
                     mem_en    <= ~req_timer;
                     mem_we    <= req_we;
                     mem_addr  <= req_adr;
                     mem_wdata <= req_dat;
                     mem_wstrb <= req_sel;
                  end
               end
            end

            DECODE: begin
               mem_en <= 1'b0;
               if (acc_pend) begin
                  state <= MEMWAIT;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            MEMWAIT: begin
               resp_ack <= 1'b1;
               acc_pend <= 1'b0;
               state    <= IDLE;
               busy     <= 1'b0;
               if (acc_int) begin
`ifdef SCANCHAIN_HOST_TIMER_EN
                  if (mem_addr[2]) begin
                     if (mem_we) mtimecmp <= merge(mtimecmp, mem_wdata, mem_wstrb);
                     else        resp_rdt <= mtimecmp;
                  end else begin
                     if (mem_we) mtime    <= merge(mtime, mem_wdata, mem_wstrb);
                     else        resp_rdt <= mtime;
                  end
`endif
               end else if (!mem_we) begin
                  resp_rdt <= mem_rdata;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scanchain_host.sv
// Directed self-checking bench for scanchain_host with a behavioural 70-bit scan chain and 1-cycle memory.
module tb_scanchain_host;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        sc_clk_out;
   logic        sc_data_out;
   logic        sc_select_out;
   logic        sc_data_in;
   logic        serv_clk_out;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic        ext_irq;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [69:0] req   = '0;
   logic [69:0] chain = '0;
   logic [33:0] din   = '0;
   logic [31:0] mem_val = '0;
   logic [69:0] pat;

   int          n_cyc, n_en, n_serv, n_sck;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_strb;
   logic        cap_we;

   scanchain_host dut (
      .clk(clk), .reset(reset), .run(run),
      .sc_clk_out(sc_clk_out), .sc_data_out(sc_data_out), .sc_select_out(sc_select_out),
      .sc_data_in(sc_data_in), .serv_clk_out(serv_clk_out),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .ext_irq(ext_irq), .busy(busy)
   );

   always #5 clk = ~clk;

   // Chain: select edge loads the request and applies the chain to module_data_in; otherwise shift right.
   assign sc_data_in = chain[0];
   always @(posedge sc_clk_out) begin
      if (sc_select_out) begin
         chain <= req;
         for (int k = 0; k < 34; k++) din[k] <= chain[69-k];
      end else begin
         chain <= {sc_data_out, chain[69:1]};
      end
   end

   // Memory returns data exactly one clk after mem_en, zero otherwise.
   always @(posedge clk) mem_rdata <= mem_en ? mem_val : 32'h0;

   function automatic logic [69:0] mk_req(input logic [31:0] adr, input logic [31:0] dat,
                                          input logic [3:0] sel, input logic we, input logic cyc);
      return {adr, dat, sel, we, cyc};
   endfunction

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_frame();
      int  k;
      logic prev_s, prev_c;
      n_cyc = 0; n_en = 0; n_serv = 0; n_sck = 0;
      cap_addr = '0; cap_wdata = '0; cap_strb = '0; cap_we = 1'b0;
      prev_s = 1'b0; prev_c = 1'b0;
      run = 1'b1;
      k = 0;
      while (!busy && k < 10) begin
         @(posedge clk); #1; k++;
      end
      run = 1'b0;
      if (!busy) chk("frame_start", 70'(busy), 70'd1);
      while (busy && n_cyc < 1000) begin
         if (mem_en) begin
            n_en++;
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_strb = mem_wstrb; cap_we = mem_we;
         end
         if (serv_clk_out && !prev_s) n_serv++;
         if (sc_clk_out && !prev_c) n_sck++;
         prev_s = serv_clk_out; prev_c = sc_clk_out;
         n_cyc++;
         @(posedge clk); #1;
      end
      if (busy) chk("frame_timeout", 70'(busy), 70'd0);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; ext_irq = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctl", 70'({sc_clk_out, sc_data_out, sc_select_out, serv_clk_out, mem_en, mem_we, busy, mem_wstrb}), 70'd0);
      chk("reset_bus", 70'({mem_addr, mem_wdata}), 70'd0);
      reset = 1'b0;

      // Idle chain: three frames with no request.
      for (int f = 0; f < 3; f++) begin
         do_frame();
         chk("idle_en", 70'(n_en), 70'd0);
         chk("idle_din", 70'(din), 70'd0);
         chk("idle_serv", 70'(n_serv), 70'd1);
         chk("idle_cyc", 70'(n_cyc), 70'd293);
      end
      chk("idle_sck", 70'(n_sck), 70'd72);
      chk("idle_busy", 70'(busy), 70'd0);

      // Read.
      req = mk_req(32'h100, 32'h0, 4'hF, 1'b0, 1'b1);
      mem_val = 32'hDEADBEEF;
      do_frame();
      chk("rd_en", 70'(n_en), 70'd1);
      chk("rd_addr", 70'(cap_addr), 70'h100);
      chk("rd_we", 70'(cap_we), 70'd0);
      chk("rd_strb", 70'(cap_strb), 70'hF);
      chk("rd_cyc", 70'(n_cyc), 70'd294);
      chk("rd_din0", 70'(din), 70'd0);
      do_frame();
      chk("rd_ack_din", 70'(din), 70'({32'hDEADBEEF, 1'b1, 1'b0}));
      chk("rd_stale_en", 70'(n_en), 70'd0);
      chk("rd_stale_cyc", 70'(n_cyc), 70'd293);
      req = '0;
      do_frame();
      chk("rd_ack_clr", 70'(din), 70'({32'hDEADBEEF, 1'b0, 1'b0}));
      chk("rd_clr_en", 70'(n_en), 70'd0);

      // Write.
      req = mk_req(32'h204, 32'h12345678, 4'h3, 1'b1, 1'b1);
      mem_val = 32'hCAFEF00D;
      do_frame();
      chk("wr_en", 70'(n_en), 70'd1);
      chk("wr_we", 70'(cap_we), 70'd1);
      chk("wr_strb", 70'(cap_strb), 70'h3);
      chk("wr_data", 70'(cap_wdata), 70'h12345678);
      chk("wr_addr", 70'(cap_addr), 70'h204);
      do_frame();
      chk("wr_ack_din", 70'(din), 70'({32'hDEADBEEF, 1'b1, 1'b0}));
      chk("wr_stale_en", 70'(n_en), 70'd0);
      req = '0;
      do_frame();
      chk("wr_ack_clr", 70'(din), 70'({32'hDEADBEEF, 1'b0, 1'b0}));

      // Bit order: alternating pattern, then its complement so the fields reach the memory port.
      pat = 70'h2AAAAAAAAAAAAAAAAA;
      req = pat;
      ext_irq = 1'b1;
      do_frame();
      chk("pat_en", 70'(n_en), 70'd0);
      chk("pat_irq_din", 70'(din), 70'({32'hDEADBEEF, 1'b0, 1'b1}));
      req = ~pat;
      ext_irq = 1'b0;
      mem_val = 32'h0F0F0F0F;
      do_frame();
      chk("npat_en", 70'(n_en), 70'd1);
      chk("npat_addr", 70'(cap_addr), 70'h55555555);
      chk("npat_data", 70'(cap_wdata), 70'h55555555);
      chk("npat_strb", 70'(cap_strb), 70'h5);
      chk("npat_we", 70'(cap_we), 70'd0);
      req = '0;

      // Reset at SHIFT bit 35 with an ack pending.
      run = 1'b1;
      begin
         int k;
         k = 0;
         while (!busy && k < 10) begin
            @(posedge clk); #1; k++;
         end
      end
      run = 1'b0;
      repeat (146) @(posedge clk);
      #1;
      chk("mid_busy", 70'(busy), 70'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_ctl", 70'({sc_clk_out, sc_data_out, sc_select_out, serv_clk_out, mem_en, mem_we, busy, mem_wstrb}), 70'd0);
      chk("mid_bus", 70'({mem_addr, mem_wdata}), 70'd0);
      reset = 1'b0;
      do_frame();
      chk("post_din", 70'(din), 70'd0);
      chk("post_cyc", 70'(n_cyc), 70'd293);
      chk("post_en", 70'(n_en), 70'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
